// File: rtl/spi_reg_slave.sv
// SPI mode-0 slave front end for the register file. All SPI pins are oversampled
// in clk_100m; frames are a 16-bit header (R/W + address) followed by DATA_W data bits.
module spi_reg_slave #(
   parameter int DATA_W    = 32,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk_100m,
   input  logic                 rst_n_syn,
   input  logic                 spi_sclk,
   input  logic                 spi_cs_n,
   input  logic                 spi_mosi,
   output logic                 spi_miso,
   output logic                 spi_miso_oe,
   output logic [15:0]          addr,
   output logic [DATA_W-1:0]    data_mosi,
   output logic                 data_mosi_rdy,
   output logic                 rd_req,
   input  logic [DATA_W-1:0]    rd_data,
   output logic                 busy,
   output logic [ERR_CNT_W-1:0] frame_err_cnt
);

   localparam int CNT_W = $clog2(((DATA_W > 16) ? DATA_W : 16) + 1);
   localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(15);
   localparam logic [CNT_W-1:0] DAT_LAST = CNT_W'(DATA_W - 1);
   localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_HDR   = 3'd1,
      ST_WDATA = 3'd2,
      ST_RDATA = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // [0],[1] are the synchroniser stages, [2] is the history stage for edge detect
   logic [2:0] sclk_sync_q;
   logic [2:0] cs_sync_q;
   logic [2:0] mosi_sync_q;
   logic       sclk_rise_q, sclk_fall_q, cs_rise_q, cs_fall_q;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [14:0]            hdr_q, hdr_d;
   logic [DATA_W-2:0]      dsh_q, dsh_d;
   logic [DATA_W-1:0]      rsh_q, rsh_d;
   logic                   ld_pend_q, ld_pend_d;
   logic [15:0]            addr_q, addr_d;
   logic [DATA_W-1:0]      data_q, data_d;
   logic                   rdy_q, rdy_d;
   logic                   rd_req_q, rd_req_d;
   logic                   miso_q, miso_d;
   logic                   oe_q, oe_d;
   logic                   busy_q, busy_d;
   logic [ERR_CNT_W-1:0]   err_q, err_d;

   logic                   mosi_s;
   logic [15:0]            hdr_nxt_s;
   logic [DATA_W-1:0]      dat_nxt_s;
   logic                   abort_s;

   // Pin synchronisers and single-cycle edge pulses
   always_ff @(posedge clk_100m or negedge rst_n_syn) begin
      if (!rst_n_syn) begin
         sclk_sync_q <= 3'b000;
         cs_sync_q   <= 3'b111;
         mosi_sync_q <= 3'b000;
         sclk_rise_q <= 1'b0;
         sclk_fall_q <= 1'b0;
         cs_rise_q   <= 1'b0;
         cs_fall_q   <= 1'b0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[1:0], spi_sclk};
         cs_sync_q   <= {cs_sync_q[1:0], spi_cs_n};
         mosi_sync_q <= {mosi_sync_q[1:0], spi_mosi};
         sclk_rise_q <= sclk_sync_q[1] & ~sclk_sync_q[2];
         sclk_fall_q <= ~sclk_sync_q[1] & sclk_sync_q[2];
         cs_rise_q   <= cs_sync_q[1] & ~cs_sync_q[2];
         cs_fall_q   <= ~cs_sync_q[1] & cs_sync_q[2];
      end
   end

   // History stage lines up with the registered rise pulse
   assign mosi_s    = mosi_sync_q[2];
   assign hdr_nxt_s = {hdr_q, mosi_s};
   assign dat_nxt_s = {dsh_q, mosi_s};

   // FSM and datapath state registers
   always_ff @(posedge clk_100m or negedge rst_n_syn) begin
      if (!rst_n_syn) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         hdr_q     <= 15'd0;
         dsh_q     <= '0;
         rsh_q     <= '0;
         ld_pend_q <= 1'b0;
         addr_q    <= 16'd0;
         data_q    <= '0;
         rdy_q     <= 1'b0;
         rd_req_q  <= 1'b0;
         miso_q    <= 1'b0;
         oe_q      <= 1'b0;
         busy_q    <= 1'b0;
         err_q     <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hdr_q     <= hdr_d;
         dsh_q     <= dsh_d;
         rsh_q     <= rsh_d;
         ld_pend_q <= ld_pend_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         rdy_q     <= rdy_d;
         rd_req_q  <= rd_req_d;
         miso_q    <= miso_d;
         oe_q      <= oe_d;
         busy_q    <= busy_d;
         err_q     <= err_d;
      end
   end

   // Next-state and output decode
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hdr_d     = hdr_q;
      dsh_d     = dsh_q;
      rsh_d     = rsh_q;
      ld_pend_d = 1'b0;
      addr_d    = addr_q;
      data_d    = data_q;
      rdy_d     = 1'b0;
      rd_req_d  = 1'b0;
      miso_d    = miso_q;
      err_d     = err_q;
      abort_s   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            miso_d = 1'b0;
            if (cs_fall_q) begin
               state_d = ST_HDR;
               cnt_d   = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_HDR: begin
            miso_d = 1'b0;
            if (cs_rise_q) begin
               abort_s = 1'b1;
            end else if (sclk_rise_q) begin
               hdr_d = hdr_nxt_s[14:0];
               if (cnt_q == HDR_LAST) begin
                  cnt_d = '0;
                  if (hdr_nxt_s[15]) begin
                     state_d = ST_WDATA;
                  end else begin
                     // Reads publish the address now; writes only at the strobe
                     addr_d    = {1'b0, hdr_nxt_s[14:0]};
                     rd_req_d  = 1'b1;
                     ld_pend_d = 1'b1;
                     state_d   = ST_RDATA;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end else begin
               state_d = ST_HDR;
            end
         end
         ST_WDATA: begin
            miso_d = 1'b0;
            if (sclk_rise_q && (cnt_q == DAT_LAST)) begin
               addr_d  = {1'b0, hdr_q};
               data_d  = dat_nxt_s;
               rdy_d   = 1'b1;
               state_d = cs_rise_q ? ST_IDLE : ST_DONE;
            end else if (cs_rise_q) begin
               abort_s = 1'b1;
            end else if (sclk_rise_q) begin
               dsh_d = dat_nxt_s[DATA_W-2:0];
               cnt_d = cnt_q + CNT_W'(1);
            end else begin
               state_d = ST_WDATA;
            end
         end
         ST_RDATA: begin
            if (ld_pend_q) begin
               rsh_d = rd_data;
            end else begin
               rsh_d = rsh_q;
            end
            if (sclk_rise_q && (cnt_q == DAT_LAST)) begin
               state_d = cs_rise_q ? ST_IDLE : ST_DONE;
            end else if (cs_rise_q) begin
               abort_s = 1'b1;
            end else if (sclk_rise_q) begin
               cnt_d = cnt_q + CNT_W'(1);
            end else if (sclk_fall_q) begin
               miso_d = rsh_q[DATA_W-1];
               rsh_d  = {rsh_q[DATA_W-2:0], 1'b0};
            end else begin
               state_d = ST_RDATA;
            end
         end
         ST_DONE: begin
            if (cs_rise_q) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (abort_s) begin
         state_d = ST_IDLE;
         if (err_q != ERR_MAX) begin
            err_d = err_q + ERR_CNT_W'(1);
         end else begin
            err_d = err_q;
         end
      end else begin
         err_d = err_d;
      end

      oe_d   = ~cs_sync_q[1];
      busy_d = (state_d != ST_IDLE);
   end

   assign spi_miso      = miso_q;
   assign spi_miso_oe   = oe_q;
   assign addr          = addr_q;
   assign data_mosi     = data_q;
   assign data_mosi_rdy = rdy_q;
   assign rd_req        = rd_req_q;
   assign busy          = busy_q;
   assign frame_err_cnt = err_q;

endmodule
